mbc_banked: RTL and testbench
=============================

# mbc_banked

Parametrised banked-cartridge mapper for the Game Boy cart path: it decodes CPU writes to 0x0000-0x7FFF and drives the ROM bank, cartridge RAM address and RAM read gating. It supports an MBC1-compatible mode and an MBC5-class mode with wider bank registers and an optional rumble motor output. It adds a battery-RAM dirty tracker with a save request/acknowledge handshake, so the save system can flush cartridge RAM once writes go idle. It sits alongside the other mappers on the shared cart bus; its outputs are driven only while `enable` is high.

## Interface
- MODE, 1, 0 = MBC1-compatible, 1 = MBC5-class
- ROM_BANK_W, 9, ROM bank register width in 16 KB banks (7..9)
- RAM_BANK_W, 4, RAM bank width in 8 KB banks (2..4)
- RUMBLE, 0, 1 = in MODE 1, RAM-bank bit 3 drives the motor instead of RAM addressing
- RUMBLE_HOLD, 255, minimum motor-on stretch, in ce_cpu ticks
- IDLE_CYCLES, 65535, ce_cpu ticks without a RAM write before a save is requested
- clk_sys  in  1  system clock; one clock; reset is synchronous and active-high
- reset  in  1  synchronous active-high reset
- ce_cpu  in  1  CPU clock enable; all register writes and counters advance only on ce_cpu
- enable  in  1  mapper selected; when low, outputs are high-Z and all state is held at reset values
- savestate_load  in  1  load registers from savestate_data
- savestate_data  in  32  [8:0] rom bank, [12:9] ram bank, [13] mode, [15] ram enable, [16] dirty
- savestate_back  out  32  same packing; unused bits 0
- has_ram, has_battery  in  1  cartridge header flags
- rom_mask  in  ROM_BANK_W  mirroring mask for the ROM bank
- ram_mask  in  RAM_BANK_W  mirroring mask for the RAM bank
- cart_addr  in  16  CPU address
- cart_wr  in  1  CPU write strobe
- cart_di  in  8  CPU write data
- cram_di  in  8  cartridge RAM read data
- cram_do  out  8  RAM data to CPU; 0xFF when RAM is disabled
- cram_addr  out  RAM_BANK_W+13  {ram bank, cart_addr[12:0]}
- mbc_bank  out  ROM_BANK_W+1  {rom bank, cart_addr[13]}
- ram_enabled  out  1  ram enable register AND has_ram
- rumble  out  1  stretched motor drive
- save_req  out  1  level request to flush battery RAM
- save_ack  in  1  single-cycle acknowledge from the save system

## Operation
- Register writes require ce_cpu & cart_wr & ~cart_addr[15]:
  - 0x0000-0x1FFF: ram enable <= (cart_di[3:0]==0xA).
  - MODE 0:
    - 0x2000-0x3FFF: low5 <= cart_di[4:0]; 0 is stored as 1.
    - 0x4000-0x5FFF: bank2 <= cart_di[1:0].
    - 0x6000-0x7FFF: mode <= cart_di[0].
  - MODE 1:
    - 0x2000-0x2FFF: rom[7:0] <= cart_di.
    - 0x3000-0x3FFF: rom[8] <= cart_di[0]. Bank 0 is legal.
    - 0x4000-0x5FFF: ram bank <= cart_di[3:0].
    - 0x6000-0x7FFF: ignored.
- ROM bank:
  - MODE 0: region 0x0000-0x3FFF uses low5 = 0; bank2 is gated by (cart_addr[14] | mode); bank = {bank2, low5}, zero-extended to ROM_BANK_W.
  - MODE 1: bank = 0 for 0x0000-0x3FFF, otherwise the rom register.
  - Both modes: bank is ANDed with rom_mask.
- RAM bank:
  - MODE 0: bank2 & {2{mode}}.
  - MODE 1: the ram register. When RUMBLE=1, bit 3 is forced to 0 in cram_addr.
  - Both modes: bank is ANDed with ram_mask.
- Rumble (MODE 1 and RUMBLE=1 only; otherwise rumble = 0):
  - rumble = 1 while ram bit 3 is set.
  - After bit 3 clears, rumble holds for RUMBLE_HOLD ce_cpu ticks, then drops.
  - Setting bit 3 again reloads the hold counter.
- Dirty tracker FSM, active only when has_battery & has_ram:
  - A RAM write is ce_cpu & cart_wr & cart_addr[15:13]==3'b101 & ram_enabled.
  - CLEAN: a RAM write -> DIRTY, with the idle counter cleared.
  - DIRTY: each RAM write clears the counter; otherwise the counter advances on ce_cpu.
  - DIRTY -> REQ when the counter reaches IDLE_CYCLES-1, or when a write disables RAM (the ram enable falling edge).
  - REQ: save_req = 1. On save_ack -> CLEAN.
  - If a RAM write occurred in REQ (including the ack cycle), save_ack instead goes -> DIRTY with the counter cleared.
  - save_ack outside REQ is ignored.
- Savestate: savestate_load & enable loads all registers, with priority over CPU writes. Dirty=1 loads the FSM into DIRTY with the counter cleared.

## Timing
- Reset values:
  - Register outputs: rom bank 1 (MODE 0 low5=1; MODE 1 rom=1), ram bank 0, mode 0, ram enable 0.
  - FSM = CLEAN, idle counter 0, rumble counter 0.
  - Derived outputs: save_req 0, rumble 0, ram_enabled 0, cram_do 0xFF.
- Priority: reset, then enable low, then savestate_load, then CPU write.
- Register writes take effect on the clk_sys edge where the write qualifies. mbc_bank, cram_addr and cram_do are combinational from the registers and cart_addr (0 extra cycles).
- save_req is registered. It rises 1 cycle after the terminal ce_cpu tick and stays high until the edge that samples save_ack.
- Reset or enable low while in REQ drops save_req on the next edge; the dirty state is lost.
- The idle counter saturates at IDLE_CYCLES-1 and never wraps. The rumble counter stops at 0.

## Test plan
- MODE 0, rom_mask=0x7F: write 0x00 to 0x2000 and 0x02 to 0x4000, read 0x4000 -> mbc_bank[7:1]=0x41. Set mode=1, read 0x0000 -> bank 0x40.
- MODE 1, ROM_BANK_W=9: write 0x00 to 0x2000 and 0x01 to 0x3000 -> bank 0x100 at 0x4000. Write 0x00 to 0x3000 -> bank 0x000 at 0x4000 (no zero remap).
- Battery RAM, IDLE_CYCLES=16: enable RAM, write 0xA000 -> save_req high exactly 16 ce ticks plus 1 cycle later. Pulse save_ack -> save_req low next edge, FSM CLEAN.
- In REQ, a RAM write on the same cycle as save_ack -> save_req drops, then reasserts after 16 further idle ticks.
- Write 0x0A then 0x00 to 0x0000 after a RAM write -> save_req rises on the next edge without waiting for the idle count. has_battery=0 -> save_req never rises.
- MODE 1, RUMBLE=1, RUMBLE_HOLD=4: write 0x08 then 0x00 to 0x4000 -> rumble stays high for 4 ce ticks after the clear. cram_addr[16] stays 0 throughout. Reset mid-hold -> rumble 0 next edge.

Source files
------------

// File: rtl/mbc_banked.sv
// rtl/mbc_banked.sv - banked cartridge mapper (MBC1/MBC5-class) with rumble stretch and battery-RAM dirty tracker
module mbc_banked #(
  parameter int MODE        = 0,
  parameter int ROM_BANK_W  = 9,
  parameter int RAM_BANK_W  = 4,
  parameter int RUMBLE      = 0,
  parameter int RUMBLE_HOLD = 255,
  parameter int IDLE_CYCLES = 65535
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_cpu,
  input  logic                    enable,
  input  logic                    savestate_load,
  input  logic [31:0]             savestate_data,
  output logic [31:0]             savestate_back,
  input  logic                    has_ram,
  input  logic                    has_battery,
  input  logic [ROM_BANK_W-1:0]   rom_mask,
  input  logic [RAM_BANK_W-1:0]   ram_mask,
  input  logic [15:0]             cart_addr,
  input  logic                    cart_wr,
  input  logic [7:0]              cart_di,
  input  logic [7:0]              cram_di,
  output logic [7:0]              cram_do,
  output logic [RAM_BANK_W+12:0]  cram_addr,
  output logic [ROM_BANK_W:0]     mbc_bank,
  output logic                    ram_enabled,
  output logic                    rumble,
  output logic                    save_req,
  input  logic                    save_ack
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int RW = $clog2(RUMBLE_HOLD + 2);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LOAD = RW'(RUMBLE_HOLD);
  localparam bit RUMBLE_EN = (MODE == 1) && (RUMBLE == 1);

  typedef enum logic [1:0] {ST_CLEAN, ST_DIRTY, ST_REQ} state_t;

  // MODE 0 keeps low5 in rom_q[4:0] and bank2 in ram_q[1:0]
  logic [8:0]    rom_q, rom_d;
  logic [3:0]    ram_q, ram_d;
  logic          mode_q, mode_d;
  logic          ram_en_q, ram_en_d;
  state_t        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          pend_q, pend_d;
  logic [RW-1:0] rum_q, rum_d;

  logic       wr_reg, track, ram_en_i, ram_wr, ram_off;
  logic [8:0] rom_bank;
  logic [3:0] ram_bank;

  assign wr_reg   = ce_cpu & cart_wr & ~cart_addr[15];
  assign track    = has_battery & has_ram;
  assign ram_en_i = ram_en_q & has_ram;
  assign ram_wr   = ce_cpu & cart_wr & (cart_addr[15:13] == 3'b101) & ram_en_i & track;
  assign ram_off  = wr_reg & (cart_addr[14:13] == 2'b00) & (cart_di[3:0] != 4'hA) & ram_en_q;

  always_comb begin
    rom_d    = rom_q;
    ram_d    = ram_q;
    mode_d   = mode_q;
    ram_en_d = ram_en_q;
    state_d  = state_q;
    idle_d   = idle_q;
    pend_d   = pend_q;
    rum_d    = rum_q;

    if (savestate_load) begin
      rom_d    = savestate_data[8:0];
      ram_d    = savestate_data[12:9];
      mode_d   = savestate_data[13];
      ram_en_d = savestate_data[15];
    end else if (wr_reg) begin
      case (cart_addr[14:13])
        2'b00: ram_en_d = (cart_di[3:0] == 4'hA);
        2'b01: begin
          if (MODE == 0) rom_d = {4'd0, (cart_di[4:0] == 5'd0) ? 5'd1 : cart_di[4:0]};
          else if (!cart_addr[12]) rom_d[7:0] = cart_di;
          else rom_d[8] = cart_di[0];
        end
        2'b10: ram_d = (MODE == 0) ? {2'b00, cart_di[1:0]} : cart_di[3:0];
        default: if (MODE == 0) mode_d = cart_di[0];
      endcase
    end

    if (savestate_load) begin
      state_d = (savestate_data[16] & track) ? ST_DIRTY : ST_CLEAN;
      idle_d  = '0;
      pend_d  = 1'b0;
    end else if (!track) begin
      state_d = ST_CLEAN;
      idle_d  = '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAN: if (ram_wr) begin
          state_d = ST_DIRTY;
          idle_d  = '0;
        end
        ST_DIRTY: begin
          if (ram_wr) idle_d = '0;
          else if (ram_off) state_d = ST_REQ;
          else if (ce_cpu) begin
            if (idle_q == IDLE_LAST) state_d = ST_REQ;
            else idle_d = idle_q + 1'b1;
          end
        end
        ST_REQ: begin
          // a write seen anywhere in REQ means the flush being acked is already stale
          if (save_ack) begin
            state_d = (pend_q | ram_wr) ? ST_DIRTY : ST_CLEAN;
            idle_d  = '0;
            pend_d  = 1'b0;
          end else if (ram_wr) pend_d = 1'b1;
        end
        default: state_d = ST_CLEAN;
      endcase
    end

    if (!RUMBLE_EN) rum_d = '0;
    else if (ram_q[3]) rum_d = HOLD_LOAD;
    else if (ce_cpu && rum_q != '0) rum_d = rum_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      rom_q    <= 9'd1;
      ram_q    <= 4'd0;
      mode_q   <= 1'b0;
      ram_en_q <= 1'b0;
      state_q  <= ST_CLEAN;
      idle_q   <= '0;
      pend_q   <= 1'b0;
      rum_q    <= '0;
    end else begin
      rom_q    <= rom_d;
      ram_q    <= ram_d;
      mode_q   <= mode_d;
      ram_en_q <= ram_en_d;
      state_q  <= state_d;
      idle_q   <= idle_d;
      pend_q   <= pend_d;
      rum_q    <= rum_d;
    end
  end

  always_comb begin
    if (MODE == 0) begin
      rom_bank = {2'b00, (cart_addr[14] | mode_q) ? ram_q[1:0] : 2'b00,
                  cart_addr[14] ? rom_q[4:0] : 5'd0};
      ram_bank = {2'b00, ram_q[1:0] & {2{mode_q}}};
    end else begin
      rom_bank = cart_addr[14] ? rom_q : 9'd0;
      ram_bank = {(RUMBLE == 1) ? 1'b0 : ram_q[3], ram_q[2:0]};
    end
  end

  // shared cart bus: release every output while another mapper is selected
  assign mbc_bank       = enable ? {rom_bank[ROM_BANK_W-1:0] & rom_mask, cart_addr[13]} : 'z;
  assign cram_addr      = enable ? {ram_bank[RAM_BANK_W-1:0] & ram_mask, cart_addr[12:0]} : 'z;
  assign cram_do        = enable ? (ram_en_i ? cram_di : 8'hFF) : 'z;
  assign ram_enabled    = enable ? ram_en_i : 1'bz;
  assign rumble         = enable ? (RUMBLE_EN && (ram_q[3] || rum_q != '0)) : 1'bz;
  assign save_req       = enable ? (state_q == ST_REQ) : 1'bz;
  assign savestate_back = enable ? {15'd0, state_q != ST_CLEAN, ram_en_q, 1'b0, mode_q, ram_q, rom_q} : 'z;
endmodule

// File: tb/tb_mbc_banked.sv
// tb/tb_mbc_banked.sv - self-checking bench for mbc_banked in MODE 0 and MODE 1 (rumble) configurations
module tb_mbc_banked;
  logic        clk_sys = 1'b0, reset = 1'b1, ce_cpu = 1'b1, enable = 1'b1;
  logic        savestate_load = 1'b0, has_ram = 1'b1, has_battery = 1'b0;
  logic        cart_wr = 1'b0, save_ack = 1'b0;
  logic [31:0] savestate_data = 32'd0;
  logic [15:0] cart_addr = 16'd0;
  logic [7:0]  cart_di = 8'd0, cram_di = 8'h5A;
  logic [8:0]  rom_mask0 = 9'h07F, rom_mask1 = 9'h1FF;
  logic [3:0]  ram_mask = 4'hF;

  wire [31:0] sb0, sb1;
  wire [7:0]  do0, do1;
  wire [16:0] a0, a1;
  wire [9:0]  b0, b1;
  wire        ren0, ren1, rum0, rum1, req0, req1;

  int n_chk = 0, n_fail = 0;

  mbc_banked #(.MODE(0), .ROM_BANK_W(9), .RAM_BANK_W(4), .RUMBLE(0), .RUMBLE_HOLD(255), .IDLE_CYCLES(16)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .enable(enable),
    .savestate_load(savestate_load), .savestate_data(savestate_data), .savestate_back(sb0),
    .has_ram(has_ram), .has_battery(has_battery), .rom_mask(rom_mask0), .ram_mask(ram_mask),
    .cart_addr(cart_addr), .cart_wr(cart_wr), .cart_di(cart_di), .cram_di(cram_di),
    .cram_do(do0), .cram_addr(a0), .mbc_bank(b0), .ram_enabled(ren0), .rumble(rum0),
    .save_req(req0), .save_ack(save_ack));

  mbc_banked #(.MODE(1), .ROM_BANK_W(9), .RAM_BANK_W(4), .RUMBLE(1), .RUMBLE_HOLD(4), .IDLE_CYCLES(16)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .enable(enable),
    .savestate_load(savestate_load), .savestate_data(savestate_data), .savestate_back(sb1),
    .has_ram(has_ram), .has_battery(has_battery), .rom_mask(rom_mask1), .ram_mask(ram_mask),
    .cart_addr(cart_addr), .cart_wr(cart_wr), .cart_di(cart_di), .cram_di(cram_di),
    .cram_do(do1), .cram_addr(a1), .mbc_bank(b1), .ram_enabled(ren1), .rumble(rum1),
    .save_req(req1), .save_ack(save_ack));

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  typedef struct packed {
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [8:0]  e0, e1;
    logic [3:0]  r0, r1;
    logic        ren;
  } vec_t;
  vec_t tbl [14];

  // reference state: MODE 0 registers and MODE 1 registers kept as plain integers
  int m_low5, m_bank2, m_mode, m_rom, m_ram, m_ren;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cart_wr = 1'b0; save_ack = 1'b0; savestate_load = 1'b0; ce_cpu = 1'b1;
    clk1();
    reset = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cart_addr = a; cart_di = d; cart_wr = 1'b1;
    clk1();
    cart_wr = 1'b0;
  endtask

  // counts ce ticks after the current point until save_req rises (bounded)
  task automatic wait_req(input string nm, input int period, input int ack_at);
    int ticks = 0;
    int cyc = 0;
    while (!req0 && cyc < 100) begin
      ce_cpu = ((cyc % period) == 0);
      save_ack = (ticks == ack_at) && ce_cpu;
      clk1();
      if (ce_cpu) ticks++;
      cyc++;
    end
    ce_cpu = 1'b1; save_ack = 1'b0;
    chk(nm, 32'(ticks), 32'd16);
    chk({nm, "_dut1"}, 32'(req1), 32'd1);
  endtask

  function automatic int exp_rom0(input int a);
    int lo, hi;
    lo = (a >= 'h4000) ? m_low5 : 0;
    hi = (a >= 'h4000 || m_mode != 0) ? m_bank2 : 0;
    return (hi * 32 + lo) % 128;
  endfunction

  function automatic int exp_rom1(input int a);
    return (a >= 'h4000) ? m_rom : 0;
  endfunction

  task automatic model_wr(input int a, input int d);
    if (a < 'h2000) m_ren = ((d % 16) == 10);
    else if (a < 'h4000) begin
      m_low5 = (d % 32 == 0) ? 1 : d % 32;
      if (a < 'h3000) m_rom = (m_rom / 256) * 256 + d;
      else m_rom = (m_rom % 256) + (d % 2) * 256;
    end else if (a < 'h6000) begin
      m_bank2 = d % 4;
      m_ram = d % 16;
    end else m_mode = d % 2;
  endtask

  initial begin
    int a, d, seen, hold;
    tbl[0]  = '{16'h2000, 8'h00, 16'h4000, 9'h001, 9'h000, 4'd0, 4'd0, 1'b0};
    tbl[1]  = '{16'h4000, 8'h02, 16'h4000, 9'h041, 9'h000, 4'd0, 4'd2, 1'b0};
    tbl[2]  = '{16'h3000, 8'h01, 16'h4000, 9'h041, 9'h100, 4'd0, 4'd2, 1'b0};
    tbl[3]  = '{16'h6000, 8'h01, 16'h0000, 9'h040, 9'h000, 4'd2, 4'd2, 1'b0};
    tbl[4]  = '{16'h3000, 8'h00, 16'h4000, 9'h041, 9'h000, 4'd2, 4'd2, 1'b0};
    tbl[5]  = '{16'h2000, 8'h1F, 16'h7FFF, 9'h05F, 9'h01F, 4'd2, 4'd2, 1'b0};
    tbl[6]  = '{16'h2100, 8'hFF, 16'h6000, 9'h05F, 9'h0FF, 4'd2, 4'd2, 1'b0};
    tbl[7]  = '{16'h4000, 8'h03, 16'h4000, 9'h07F, 9'h0FF, 4'd3, 4'd3, 1'b0};
    tbl[8]  = '{16'h6000, 8'h00, 16'h0000, 9'h000, 9'h000, 4'd0, 4'd3, 1'b0};
    tbl[9]  = '{16'h3000, 8'h01, 16'h5000, 9'h061, 9'h1FF, 4'd0, 4'd3, 1'b0};
    tbl[10] = '{16'h2000, 8'h20, 16'h4000, 9'h061, 9'h120, 4'd0, 4'd3, 1'b0};
    tbl[11] = '{16'h1000, 8'h0A, 16'h4000, 9'h061, 9'h120, 4'd0, 4'd3, 1'b1};
    tbl[12] = '{16'h4000, 8'h0F, 16'h4000, 9'h061, 9'h120, 4'd0, 4'd7, 1'b1};
    tbl[13] = '{16'h4000, 8'h01, 16'h4000, 9'h021, 9'h120, 4'd0, 4'd1, 1'b1};

    do_reset();
    cart_addr = 16'h4000; #1;
    chk("rst_bank0", 32'(b0), 32'h002);
    chk("rst_bank1", 32'(b1), 32'h002);
    cart_addr = 16'hA000; #1;
    chk("rst_cram_addr1", 32'(a1), 32'h0000);
    chk("rst_ren", 32'({ren0, ren1}), 32'd0);
    chk("rst_cram_do", 32'({do0, do1}), 32'hFFFF);
    chk("rst_req_rum", 32'({req0, req1, rum0, rum1}), 32'd0);
    chk("rst_sb1", sb1, 32'h1);

    for (int i = 0; i < 14; i++) begin
      cpu_wr(tbl[i].wa, tbl[i].wd);
      cart_addr = tbl[i].ra; #1;
      chk($sformatf("tbl%0d_bank0", i), 32'(b0), 32'({tbl[i].e0, tbl[i].ra[13]}));
      chk($sformatf("tbl%0d_bank1", i), 32'(b1), 32'({tbl[i].e1, tbl[i].ra[13]}));
      chk($sformatf("tbl%0d_cram0", i), 32'(a0), 32'({tbl[i].r0, tbl[i].ra[12:0]}));
      chk($sformatf("tbl%0d_cram1", i), 32'(a1), 32'({tbl[i].r1, tbl[i].ra[12:0]}));
      chk($sformatf("tbl%0d_ren", i), 32'({ren0, ren1}), 32'({tbl[i].ren, tbl[i].ren}));
      chk($sformatf("tbl%0d_do", i), 32'(do0), tbl[i].ren ? 32'h5A : 32'hFF);
    end

    // enable low returns registers to reset values
    enable = 1'b0; clk1(); enable = 1'b1; cart_addr = 16'h4000; #1;
    chk("enable_low_bank1", 32'(b1), 32'h002);
    chk("enable_low_ren", 32'(ren1), 32'd0);

    // randomized register traffic against the reference model
    do_reset();
    m_low5 = 1; m_bank2 = 0; m_mode = 0; m_rom = 1; m_ram = 0; m_ren = 0;
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(0, 16'h7FFF));
      d = int'($urandom_range(0, 255));
      ce_cpu = ($urandom_range(0, 3) != 0);
      cart_wr = ($urandom_range(0, 1) != 0);
      cart_addr = 16'(a); cart_di = 8'(d);
      clk1();
      if (ce_cpu && cart_wr) model_wr(a, d);
      cart_wr = 1'b0;
      a = int'($urandom_range(0, 16'h7FFF));
      cart_addr = 16'(a); #1;
      chk("rnd_bank0", 32'(b0), 32'(exp_rom0(a) * 2 + (a / 'h2000) % 2));
      chk("rnd_bank1", 32'(b1), 32'(exp_rom1(a) * 2 + (a / 'h2000) % 2));
      chk("rnd_cram0", 32'(a0), 32'((m_mode != 0 ? m_bank2 : 0) * 'h2000 + a % 'h2000));
      chk("rnd_cram1", 32'(a1), 32'((m_ram % 8) * 'h2000 + a % 'h2000));
      chk("rnd_ren", 32'({ren0, ren1}), 32'({m_ren[0], m_ren[0]}));
    end
    ce_cpu = 1'b1;

    // dirty tracker: idle timeout, ack, ack racing a write, ignored ack, ce gating
    do_reset();
    has_battery = 1'b1;
    cpu_wr(16'h0000, 8'h0A);
    cpu_wr(16'hA000, 8'h11);
    wait_req("idle_latency", 1, -1);
    save_ack = 1'b1; clk1(); save_ack = 1'b0;
    chk("ack_clears_req", 32'(req0), 32'd0);
    chk("ack_clean_state", 32'(sb0[16]), 32'd0);
    cpu_wr(16'hA123, 8'h22);
    wait_req("idle_latency_ack_ignored", 1, 5);
    save_ack = 1'b1; cart_addr = 16'hA000; cart_wr = 1'b1; clk1();
    save_ack = 1'b0; cart_wr = 1'b0;
    chk("ack_write_race_req", 32'(req0), 32'd0);
    chk("ack_write_race_dirty", 32'(sb0[16]), 32'd1);
    wait_req("reassert_latency", 1, -1);
    save_ack = 1'b1; clk1(); save_ack = 1'b0;
    cpu_wr(16'hBFFF, 8'h33);
    wait_req("ce_gated_latency", 2, -1);
    save_ack = 1'b1; clk1(); save_ack = 1'b0;
    cpu_wr(16'hA000, 8'h44);
    cpu_wr(16'h0000, 8'h00);
    chk("ram_disable_req0", 32'(req0), 32'd1);
    chk("ram_disable_req1", 32'(req1), 32'd1);
    reset = 1'b1; clk1(); reset = 1'b0;
    chk("reset_in_req", 32'({req0, sb0[16]}), 32'd0);

    has_battery = 1'b0;
    cpu_wr(16'h0000, 8'h0A);
    cpu_wr(16'hA000, 8'h55);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      clk1();
      if (req0 || req1) seen = 1;
    end
    chk("no_battery_no_req", 32'(seen), 32'd0);

    // savestate load wins over a simultaneous CPU write
    do_reset();
    has_battery = 1'b1;
    savestate_data = 32'hFFFF_EB23; savestate_load = 1'b1;
    cart_addr = 16'h2000; cart_di = 8'h55; cart_wr = 1'b1;
    clk1();
    savestate_load = 1'b0; cart_wr = 1'b0; cart_addr = 16'h4000; #1;
    chk("ss_back1", sb1, 32'h0001_AB23);
    chk("ss_back0", sb0, 32'h0001_AB23);
    chk("ss_bank1", 32'(b1), 32'h246);
    chk("ss_bank0", 32'(b0), 32'h046);
    chk("ss_ren", 32'({ren0, ren1}), 32'h3);
    wait_req("ss_dirty_latency", 1, -1);
    enable = 1'b0; clk1(); enable = 1'b1; #1;
    chk("enable_low_in_req", 32'({req0, req1}), 32'd0);

    // rumble stretch
    do_reset();
    has_battery = 1'b0;
    cpu_wr(16'h4000, 8'h08);
    cart_addr = 16'hA000; #1;
    chk("rumble_on", 32'(rum1), 32'd1);
    chk("rumble_addr_bit", 32'(a1[16]), 32'd0);
    cpu_wr(16'h4000, 8'h00);
    cart_addr = 16'hBFFF;
    hold = 0; seen = 0;
    while (rum1 && hold < 20) begin
      if (a1[16] || rum0) seen = 1;
      clk1();
      hold++;
    end
    chk("rumble_hold_cycles", 32'(hold), 32'd4);
    chk("rumble_bit3_masked", 32'(seen), 32'd0);
    cpu_wr(16'h4000, 8'h08);
    cpu_wr(16'h4000, 8'h00);
    clk1();
    chk("rumble_mid_hold", 32'(rum1), 32'd1);
    reset = 1'b1; clk1(); reset = 1'b0;
    chk("rumble_reset", 32'(rum1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
